cache_fill_ctrl: RTL
====================

# cache_fill_ctrl

Tag-compare and miss-fill controller for the 2-way, 64-set cache, sitting directly upstream of the metadata (tag/LRU) array and the data array. Each cycle it decodes the request address, selects the set, and compares the tags returned by the metadata array. On a hit it updates LRU. On a miss it stalls the pipeline, fetches the 8-word block from memory, writes it into the victim way, then rewrites the set's metadata.

## Interface
- BLOCK_WORDS, 8, 16-bit words per block; only 8 is supported (3-bit word counters).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  cache access requested this cycle.
- req_addr  in  16  byte address: tag [15:10], set [9:4], word [3:1].
- meta_rd  in  16  metadata for the selected set. Each way's byte (way0 = [7:0], way1 = [15:8]) holds: bit7 LRU (1 = victim candidate), bit6 valid, bits[5:0] tag.
- meta_block_en  out  64  one-hot set select, = 1 << req_addr[9:4] in IDLE and 1 << latched set otherwise.
- meta_wr_data  out  16  metadata write value.
- meta_write  out  1  full-set metadata write.
- meta_lru_en  out  1  LRU-bit-only write.
- data_way  out  1  data-array way being filled.
- data_word_en  out  8  one-hot word select for the data-array write.
- data_write  out  1  data-array write strobe; the word is mem_data.
- mem_rd  out  1  memory read request, one word per cycle.
- mem_addr  out  16  word-aligned read address.
- mem_data_valid  in  1  one returned word, in request order.
- mem_data  in  16  returned word (routed to the data array externally).
- hit  out  1  request hits this cycle.
- stall  out  1  pipeline must hold.

## Operation
- States: IDLE, FILL, DONE.
- Reset: state IDLE, both counters 0, all latches 0.
- Reset values of outputs: hit, stall, mem_rd, meta_write, meta_lru_en and data_write are 0; data_word_en is 0; mem_addr is 0.
- Hit condition in IDLE: way w matches when meta_rd[w·8+6] = 1 and meta_rd[w·8+5 : w·8] = req_addr[15:10]. hit = req_valid & (match0 | match1).
  - If both ways match (illegal state), way0 is treated as the hit way.
- Hit (combinational): meta_lru_en = 1 and meta_wr_data sets the hit way's bit7 to 0 and the other way's bit7 to 1. Other bits are don't-care, because the array writes only bit7 under lru_en.
- Miss in IDLE (req_valid & ~hit):
  - stall = 1 in the same cycle; next state is FILL.
  - Latch the tag, the set, and both metadata bytes.
  - Victim selection, in priority order: the first invalid way (way0 before way1); else the way with LRU = 1; else way0.
- FILL:
  - Issue counter ic (0..8): mem_rd = 1 while ic < 8, with mem_addr = {tag, set, ic[2:0], 1'b0}. ic increments on each issue cycle.
  - Receive counter rc (0..8): each mem_data_valid asserts data_write, with data_way = victim and data_word_en = 1 << rc; rc then increments.
  - Issue and receive may occur in the same cycle.
  - After the 8th receive (rc reaching 8), next state is DONE.
  - mem_data_valid while rc = 8 or outside FILL is ignored: no write.
- DONE, one cycle:
  - meta_write = 1.
  - meta_wr_data: the victim byte = {0, 1, latched tag}; the other byte = latched byte with bit7 forced to 1.
  - Next state is IDLE; counters clear.
- stall = 1 in the IDLE-miss cycle and throughout FILL and DONE.
- The request is re-evaluated in IDLE after DONE, where it now hits.
- req_valid and req_addr changes during FILL/DONE are ignored; the fill always completes.
- rst in any state returns the block to IDLE next edge. mem_rd drops, and no data_write or meta_write occurs in the reset cycle. Outstanding memory returns are afterwards ignored while in IDLE.

## Timing
- Hit: zero-latency. hit and meta_lru_en are combinational in the request cycle, and the LRU update commits at that edge.
- Miss, request at cycle 0 with memory latency L (word returned L cycles after issue):
  - mem_rd in cycles 1–8.
  - mem_data_valid in cycles 1+L through 8+L.
  - DONE at cycle 9+L; IDLE hit at cycle 10+L.
  - Miss penalty: 10+L cycles of stall.
- Only one miss is outstanding at a time; no request buffering.

## Test plan
- Reset: assert rst for 2 cycles with req_valid = 1 → hit, stall, mem_rd, meta_write and data_write are 0; meta_block_en = 1 << req_addr[9:4].
- Cold miss, L = 4, addr 0x1234 with all metadata 0:
  - stall rises at cycle 0.
  - mem_addr is 0x1230, 0x1232 … 0x123E in cycles 1–8.
  - data_write with data_way = 0 and word_en 0x01 → 0x80 in cycles 5–12.
  - meta_write at cycle 13 with meta_wr_data = 0x8044.
  - hit = 1 at cycle 14.
- Hit with LRU update: set holding way0 tag 0x04 and way1 tag 0x07 (both valid); request tag 0x07 → hit = 1, meta_lru_en = 1, meta_wr_data[15] = 0 and [7] = 1, no stall.
- LRU eviction: both ways valid, way1 LRU = 1, miss on a new tag → data_way = 1. In DONE, way0's tag and valid are preserved, way0 bit7 = 1, and way1 = {0, 1, newtag}.
- Reset mid-fill: rst at the 3rd word received → IDLE next cycle; mem_rd, stall and data_write are 0; later mem_data_valid pulses produce no data_write.
- Concurrent issue/receive, L = 1: mem_rd and mem_data_valid overlap in cycles 2–8 → exactly 8 data_writes with word_en 0x01 … 0x80 in order, DONE at cycle 10.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// Tag-compare and miss-fill controller for a 2-way, 64-set cache.
// IDLE compares tags and updates LRU on a hit.
// On a miss, FILL streams an 8-word block from memory into the victim way.
// DONE then rewrites the set's metadata. The request is re-evaluated afterwards.
module cache_fill_ctrl #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic [15:0] req_addr_i,
    input  logic [15:0] meta_rd_i,
    output logic [63:0] meta_block_en_o,
    output logic [15:0] meta_wr_data_o,
    output logic        meta_write_o,
    output logic        meta_lru_en_o,
    output logic        data_way_o,
    output logic [7:0]  data_word_en_o,
    output logic        data_write_o,
    output logic        mem_rd_o,
    output logic [15:0] mem_addr_o,
    input  logic        mem_data_valid_i,
    input  logic [15:0] mem_data_i,
    output logic        hit_o,
    output logic        stall_o
);

    localparam logic [3:0] WORDS_C = 4'(BLOCK_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

    // A way matches when it is valid and its stored tag equals the request tag
    function automatic logic way_match(input logic [7:0] way_meta, input logic [5:0] tag);
        return way_meta[6] && (way_meta[5:0] == tag);
    endfunction

    // Victim choice: first invalid way, else the LRU-marked way, else way0
    function automatic logic pick_victim(input logic [15:0] meta);
        logic v;
        if (!meta[6]) begin
            v = 1'b0;
        end else if (!meta[14]) begin
            v = 1'b1;
        end else if (meta[7]) begin
            v = 1'b0;
        end else if (meta[15]) begin
            v = 1'b1;
        end else begin
            v = 1'b0;
        end
        return v;
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  ic_q, ic_d;
    logic [3:0]  rc_q, rc_d;
    logic [5:0]  tag_q, tag_d;
    logic [5:0]  set_q, set_d;
    logic [15:0] meta_q, meta_d;
    logic        victim_q, victim_d;
    logic        match0_s, match1_s;

    // mem_data is routed to the data array outside this block.
    // The word offset of the request address does not affect tag lookup.
    logic unused_s;
    assign unused_s = ^{mem_data_i, req_addr_i[3:0]};

    assign match0_s = way_match(meta_rd_i[7:0], req_addr_i[15:10]);
    assign match1_s = way_match(meta_rd_i[15:8], req_addr_i[15:10]);

    // Next-state and output decode; reset forces every strobe low
    always_comb begin
        state_d         = state_q;
        ic_d            = ic_q;
        rc_d            = rc_q;
        tag_d           = tag_q;
        set_d           = set_q;
        meta_d          = meta_q;
        victim_d        = victim_q;
        hit_o           = 1'b0;
        stall_o         = 1'b0;
        mem_rd_o        = 1'b0;
        mem_addr_o      = 16'h0000;
        data_write_o    = 1'b0;
        data_word_en_o  = 8'h00;
        data_way_o      = victim_q;
        meta_write_o    = 1'b0;
        meta_lru_en_o   = 1'b0;
        meta_wr_data_o  = 16'h0000;
        meta_block_en_o = 64'd1 << set_q;

        case (state_q)
            IDLE: begin
                meta_block_en_o = 64'd1 << req_addr_i[9:4];
                if (req_valid_i && (match0_s || match1_s)) begin
                    hit_o         = 1'b1;
                    meta_lru_en_o = 1'b1;
                    if (match0_s) begin
                        meta_wr_data_o = {1'b1, meta_rd_i[14:8], 1'b0, meta_rd_i[6:0]};
                    end else begin
                        meta_wr_data_o = {1'b0, meta_rd_i[14:8], 1'b1, meta_rd_i[6:0]};
                    end
                end else if (req_valid_i) begin
                    stall_o  = 1'b1;
                    state_d  = FILL;
                    tag_d    = req_addr_i[15:10];
                    set_d    = req_addr_i[9:4];
                    meta_d   = meta_rd_i;
                    victim_d = pick_victim(meta_rd_i);
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                stall_o = 1'b1;
                if (ic_q < WORDS_C) begin
                    mem_rd_o   = 1'b1;
                    mem_addr_o = {tag_q, set_q, ic_q[2:0], 1'b0};
                    ic_d       = ic_q + 4'd1;
                end else begin
                    ic_d = ic_q;
                end
                if (mem_data_valid_i && (rc_q < WORDS_C)) begin
                    data_write_o   = 1'b1;
                    data_word_en_o = 8'd1 << rc_q[2:0];
                    rc_d           = rc_q + 4'd1;
                    if (rc_q == (WORDS_C - 4'd1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    rc_d = rc_q;
                end
            end
            DONE: begin
                stall_o      = 1'b1;
                meta_write_o = 1'b1;
                if (victim_q) begin
                    meta_wr_data_o = {2'b01, tag_q, 1'b1, meta_q[6:0]};
                end else begin
                    meta_wr_data_o = {1'b1, meta_q[14:8], 2'b01, tag_q};
                end
                state_d = IDLE;
                ic_d    = 4'd0;
                rc_d    = 4'd0;
            end
            default: begin
                state_d = IDLE;
                ic_d    = 4'd0;
                rc_d    = 4'd0;
            end
        endcase

        if (rst_i) begin
            hit_o          = 1'b0;
            stall_o        = 1'b0;
            mem_rd_o       = 1'b0;
            mem_addr_o     = 16'h0000;
            data_write_o   = 1'b0;
            data_word_en_o = 8'h00;
            meta_write_o   = 1'b0;
            meta_lru_en_o  = 1'b0;
            meta_wr_data_o = 16'h0000;
        end else begin
            hit_o = hit_o;
        end
    end

    // State, counters and miss latches with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ic_q     <= 4'd0;
            rc_q     <= 4'd0;
            tag_q    <= 6'd0;
            set_q    <= 6'd0;
            meta_q   <= 16'h0000;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ic_q     <= ic_d;
            rc_q     <= rc_d;
            tag_q    <= tag_d;
            set_q    <= set_d;
            meta_q   <= meta_d;
            victim_q <= victim_d;
        end
    end

endmodule
